// File: rtl/ac_mem_sequencer.sv
// Operand-fetch sequencer between address calculation and execute: issues up to three
// ordered reads (src1, src2, dest) over one memory read port and hands the set to execute.
module ac_mem_sequencer #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acValidIn,
    input  logic              isMemoryAccessSrc1In,
    input  logic              isMemoryAccessSrc2In,
    input  logic              isMemoryAccessDestIn,
    input  logic [ADDR_W-1:0] memoryAddressSrc1In,
    input  logic [ADDR_W-1:0] memoryAddressSrc2In,
    input  logic [ADDR_W-1:0] memoryAddressDestIn,
    input  logic              flushIn,
    output logic              stallOut,
    output logic              memReqOut,
    output logic [ADDR_W-1:0] memAddrOut,
    input  logic              memAckIn,
    input  logic [DATA_W-1:0] memDataIn,
    output logic              opValidOut,
    output logic [DATA_W-1:0] src1DataOut,
    output logic [DATA_W-1:0] src2DataOut,
    output logic [DATA_W-1:0] destDataOut,
    input  logic              readyIn,
    output logic [31:0]       readCountOut
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [2:0] {IDLE, RD_SRC1, RD_SRC2, RD_DEST, DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        flags_q;  // bit 0 src1, bit 1 src2, bit 2 dest
    logic [ADDR_W-1:0] src1_addr_q, src2_addr_q, dest_addr_q;
    logic [DATA_W-1:0] src1_data_q, src2_data_q, dest_data_q;
    logic [CNT_W-1:0]  count_q;
    logic [2:0]        flags_in;
    logic              accept;
    logic              ack_ok;

    // First pending read in fixed order, DONE when nothing is left
    function automatic state_e first_rd(input logic [2:0] f);
        if (f[0])      return RD_SRC1;
        else if (f[1]) return RD_SRC2;
        else if (f[2]) return RD_DEST;
        else           return DONE;
    endfunction

    assign flags_in = {isMemoryAccessDestIn, isMemoryAccessSrc2In, isMemoryAccessSrc1In};
    assign accept   = acValidIn && !flushIn
                      && (state_q == IDLE || (state_q == DONE && readyIn));
    assign ack_ok   = memAckIn && !flushIn
                      && (state_q == RD_SRC1 || state_q == RD_SRC2 || state_q == RD_DEST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flushIn) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = accept ? first_rd(flags_in) : IDLE;
                RD_SRC1: if (memAckIn) state_d = first_rd(flags_q & 3'b110);
                RD_SRC2: if (memAckIn) state_d = first_rd(flags_q & 3'b100);
                RD_DEST: if (memAckIn) state_d = DONE;
                DONE:    if (readyIn) state_d = accept ? first_rd(flags_in) : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Operand latches, read data capture and completed-read counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q     <= '0;
            src1_addr_q <= '0;
            src2_addr_q <= '0;
            dest_addr_q <= '0;
            src1_data_q <= '0;
            src2_data_q <= '0;
            dest_data_q <= '0;
            count_q     <= '0;
        end else if (accept) begin
            flags_q     <= flags_in;
            src1_addr_q <= memoryAddressSrc1In;
            src2_addr_q <= memoryAddressSrc2In;
            dest_addr_q <= memoryAddressDestIn;
            src1_data_q <= '0;
            src2_data_q <= '0;
            dest_data_q <= '0;
        end else if (ack_ok) begin
            count_q <= count_q + CNT_W'(1);
            case (state_q)
                RD_SRC1: src1_data_q <= memDataIn;
                RD_SRC2: src2_data_q <= memDataIn;
                RD_DEST: dest_data_q <= memDataIn;
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state; stall also sees readyIn
    always_comb begin
        memReqOut    = 1'b0;
        memAddrOut   = '0;
        opValidOut   = 1'b0;
        stallOut     = 1'b1;
        src1DataOut  = src1_data_q;
        src2DataOut  = src2_data_q;
        destDataOut  = dest_data_q;
        readCountOut = count_q;
        case (state_q)
            IDLE:    stallOut = 1'b0;
            RD_SRC1: begin memReqOut = 1'b1; memAddrOut = src1_addr_q; end
            RD_SRC2: begin memReqOut = 1'b1; memAddrOut = src2_addr_q; end
            RD_DEST: begin memReqOut = 1'b1; memAddrOut = dest_addr_q; end
            DONE:    begin opValidOut = 1'b1; stallOut = !readyIn; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ac_mem_sequencer.sv
// Scoreboard bench for ac_mem_sequencer: directed instructions push expected operand sets
// and read addresses; a memory responder and an output monitor run alongside.
module tb_ac_mem_sequencer;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    typedef struct packed {
        logic [DW-1:0] s1;
        logic [DW-1:0] s2;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          acValidIn;
    logic          isMemoryAccessSrc1In, isMemoryAccessSrc2In, isMemoryAccessDestIn;
    logic [AW-1:0] memoryAddressSrc1In, memoryAddressSrc2In, memoryAddressDestIn;
    logic          flushIn;
    logic          stallOut;
    logic          memReqOut;
    logic [AW-1:0] memAddrOut;
    logic          memAckIn;
    logic [DW-1:0] memDataIn;
    logic          opValidOut;
    logic [DW-1:0] src1DataOut, src2DataOut, destDataOut;
    logic          readyIn;
    logic [31:0]   readCountOut;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] data_q[$];
    int            tests = 0;
    int            fails = 0;
    int            ack_delay = 0;
    bit            stray_ack = 1'b0;
    logic [31:0]   exp_cnt = '0;
    bit            hold_pend = 1'b0;
    logic [AW-1:0] hold_addr = '0;

    always #5 clk = ~clk;

    ac_mem_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .acValidIn            (acValidIn),
        .isMemoryAccessSrc1In (isMemoryAccessSrc1In),
        .isMemoryAccessSrc2In (isMemoryAccessSrc2In),
        .isMemoryAccessDestIn (isMemoryAccessDestIn),
        .memoryAddressSrc1In  (memoryAddressSrc1In),
        .memoryAddressSrc2In  (memoryAddressSrc2In),
        .memoryAddressDestIn  (memoryAddressDestIn),
        .flushIn              (flushIn),
        .stallOut             (stallOut),
        .memReqOut            (memReqOut),
        .memAddrOut           (memAddrOut),
        .memAckIn             (memAckIn),
        .memDataIn            (memDataIn),
        .opValidOut           (opValidOut),
        .src1DataOut          (src1DataOut),
        .src2DataOut          (src2DataOut),
        .destDataOut          (destDataOut),
        .readyIn              (readyIn),
        .readCountOut         (readCountOut)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        addr_q.delete();
        data_q.delete();
    endtask

    // Present one instruction, queue its expectations, hold it until accepted
    task automatic issue(input logic [2:0] f, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [AW-1:0] ad, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2, input logic [DW-1:0] dd);
        exp_t e;
        bit   ok;
        e.s1 = f[0] ? d1 : '0;
        e.s2 = f[1] ? d2 : '0;
        e.d  = f[2] ? dd : '0;
        exp_q.push_back(e);
        if (f[0]) begin addr_q.push_back(a1); data_q.push_back(d1); end
        if (f[1]) begin addr_q.push_back(a2); data_q.push_back(d2); end
        if (f[2]) begin addr_q.push_back(ad); data_q.push_back(dd); end
        acValidIn            = 1'b1;
        isMemoryAccessSrc1In = f[0];
        isMemoryAccessSrc2In = f[1];
        isMemoryAccessDestIn = f[2];
        memoryAddressSrc1In  = a1;
        memoryAddressSrc2In  = a2;
        memoryAddressDestIn  = ad;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!stallOut) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL accept_timeout: stallOut still 1 after 50 cycles, required 0");
        end
        step();
        acValidIn            = 1'b0;
        isMemoryAccessSrc1In = 1'b0;
        isMemoryAccessSrc2In = 1'b0;
        isMemoryAccessDestIn = 1'b0;
    endtask

    task automatic wait_handshake();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (opValidOut && readyIn) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL handshake_timeout: opValidOut 0 after 50 cycles, required 1");
        end
        step();
    endtask

    // Memory model: acks after ack_delay wait cycles, returns queued data
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        memAckIn  = 1'b0;
        memDataIn = '0;
        forever begin
            step();
            if (memReqOut && wait_cnt >= ack_delay) begin
                memAckIn  = 1'b1;
                memDataIn = (data_q.size() > 0) ? data_q.pop_front() : 64'hDEAD_DEAD;
                wait_cnt  = 0;
            end else begin
                memAckIn  = stray_ack;
                memDataIn = stray_ack ? 64'hBAD0_BAD0 : '0;
                wait_cnt  = memReqOut ? wait_cnt + 1 : 0;
            end
        end
    end

    // Monitor: read order, request hold, completed-read count, operand sets on handshake
    always @(negedge clk) begin
        if (reset) begin
            exp_cnt   = '0;
            hold_pend = 1'b0;
        end else begin
            chk("read_count", 64'(readCountOut), 64'(exp_cnt));
            if (hold_pend) begin
                chk1("req_hold", memReqOut, 1'b1);
                chk("addr_hold", memAddrOut, hold_addr);
            end
            if (memReqOut && memAckIn && !flushIn) begin
                if (addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_read: read at 0x%0h, required none", memAddrOut);
                end else begin
                    chk("read_addr", memAddrOut, addr_q.pop_front());
                end
                exp_cnt = exp_cnt + 32'd1;
            end
            hold_pend = memReqOut && !memAckIn && !flushIn;
            hold_addr = memAddrOut;
            if (opValidOut && readyIn && !flushIn) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_opvalid: opValidOut 1, required 0");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("src1_data", src1DataOut, e.s1);
                    chk("src2_data", src2DataOut, e.s2);
                    chk("dest_data", destDataOut, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset                = 1'b0;
        acValidIn            = 1'b0;
        isMemoryAccessSrc1In = 1'b0;
        isMemoryAccessSrc2In = 1'b0;
        isMemoryAccessDestIn = 1'b0;
        memoryAddressSrc1In  = '0;
        memoryAddressSrc2In  = '0;
        memoryAddressDestIn  = '0;
        flushIn              = 1'b0;
        readyIn              = 1'b1;
        #1 reset = 1'b1;
        #2;
        chk1("rst_opvalid", opValidOut, 1'b0);
        chk1("rst_memreq", memReqOut, 1'b0);
        chk("rst_memaddr", memAddrOut, 64'h0);
        chk1("rst_stall", stallOut, 1'b0);
        chk("rst_count", 64'(readCountOut), 64'h0);
        chk("rst_dest", destDataOut, 64'h0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        step();

        // No memory operands: valid one cycle after accept
        issue(3'b000, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        @(negedge clk);
        chk1("noflag_valid", opValidOut, 1'b1);
        chk1("noflag_req", memReqOut, 1'b0);
        step();

        // All three operands, same-cycle acks
        ack_delay = 0;
        issue(3'b111, 64'h1000, 64'h2000, 64'h3000, 64'hA, 64'hB, 64'hC);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("all3_req", memReqOut, 1'b1);
        end
        @(negedge clk);
        chk1("all3_valid", opValidOut, 1'b1);
        chk("all3_count", 64'(readCountOut), 64'd3);
        step();

        // Dest only, ack delayed by three cycles
        ack_delay = 3;
        issue(3'b100, 64'h0, 64'h0, 64'h4000, 64'h0, 64'h0, 64'hD0D0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1("dest_req", memReqOut, 1'b1);
            chk("dest_addr", memAddrOut, 64'h4000);
            chk1("dest_stall", stallOut, 1'b1);
        end
        @(negedge clk);
        chk1("dest_valid", opValidOut, 1'b1);
        step();

        // Execute backpressure, then back-to-back accept with no bubble
        ack_delay = 0;
        readyIn   = 1'b0;
        issue(3'b001, 64'h5000, 64'h0, 64'h0, 64'h55, 64'h0, 64'h0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk1("hold_valid", opValidOut, 1'b1);
            chk("hold_src1", src1DataOut, 64'h55);
            chk1("hold_stall", stallOut, 1'b1);
        end
        step();
        readyIn = 1'b1;
        issue(3'b010, 64'h0, 64'h6000, 64'h0, 64'h0, 64'h66, 64'h0);
        @(negedge clk);
        chk1("b2b_req", memReqOut, 1'b1);
        chk("b2b_addr", memAddrOut, 64'h6000);
        wait_handshake();

        // Flush during RD_SRC1, late ack one cycle after the flush
        ack_delay = 20;
        issue(3'b011, 64'h7000, 64'h7100, 64'h0, 64'h77, 64'h71, 64'h0);
        @(negedge clk);
        chk1("fl_req", memReqOut, 1'b1);
        step();
        flushIn = 1'b1;
        clear_sb();
        @(negedge clk);
        step();
        flushIn   = 1'b0;
        stray_ack = 1'b1;
        @(negedge clk);
        chk1("fl_req_drop", memReqOut, 1'b0);
        chk1("fl_stall", stallOut, 1'b0);
        chk1("fl_valid", opValidOut, 1'b0);
        step();
        stray_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("fl_valid_never", opValidOut, 1'b0);
            chk("fl_count", 64'(readCountOut), 64'd6);
        end
        step();

        // Ack arriving in the flush cycle itself is neither captured nor counted
        ack_delay = 1;
        issue(3'b001, 64'h8000, 64'h0, 64'h0, 64'h88, 64'h0, 64'h0);
        @(negedge clk);
        chk1("fla_req", memReqOut, 1'b1);
        step();
        flushIn = 1'b1;
        clear_sb();
        @(negedge clk);
        step();
        flushIn = 1'b0;
        @(negedge clk);
        chk1("fla_req_drop", memReqOut, 1'b0);
        chk1("fla_valid", opValidOut, 1'b0);
        chk("fla_count", 64'(readCountOut), 64'd6);
        step();

        // Asynchronous reset mid RD_SRC2
        ack_delay = 5;
        issue(3'b010, 64'h0, 64'h9000, 64'h0, 64'h0, 64'h99, 64'h0);
        @(negedge clk);
        chk1("mid_req", memReqOut, 1'b1);
        step();
        reset = 1'b1;
        clear_sb();
        #1;
        chk1("mrst_req", memReqOut, 1'b0);
        chk1("mrst_valid", opValidOut, 1'b0);
        chk1("mrst_stall", stallOut, 1'b0);
        chk("mrst_addr", memAddrOut, 64'h0);
        chk("mrst_count", 64'(readCountOut), 64'h0);
        step();
        reset = 1'b0;
        step();

        // Normal operation after reset
        ack_delay = 0;
        issue(3'b111, 64'hA000, 64'hB000, 64'hC000, 64'h1, 64'h2, 64'h3);
        wait_handshake();
        @(negedge clk);
        chk("post_rst_count", 64'(readCountOut), 64'd3);
        repeat (3) step();
        chk("sb_ops_left", 64'(exp_q.size()), 64'd0);
        chk("sb_reads_left", 64'(addr_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ac_mem_sequencer.md
# ac_mem_sequencer

Sequences the memory operand reads produced by the address-calculation stage over one shared data-memory read port. It sits between address calculation and execute. Per instruction it issues up to three reads in fixed order: src1, src2, dest (the old value, for read-modify-write). It stalls address calculation while busy and presents the gathered operand data to execute with a valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 64, memory address width
- DATA_W, 64, memory read data width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- acValidIn  in  1  address-calculation result valid (isAddressCalculationSuccessful)
- isMemoryAccessSrc1In / isMemoryAccessSrc2In / isMemoryAccessDestIn  in  1 each  operand is a memory reference
- memoryAddressSrc1In / memoryAddressSrc2In / memoryAddressDestIn  in  ADDR_W each  computed effective addresses
- flushIn  in  1  synchronous pipeline flush
- stallOut  out  1  cannot accept from address calculation this cycle
- memReqOut  out  1  read request
- memAddrOut  out  ADDR_W  read address
- memAckIn  in  1  read data valid this cycle
- memDataIn  in  DATA_W  read data
- opValidOut  out  1  operand set complete
- src1DataOut / src2DataOut / destDataOut  out  DATA_W each  loaded values; 0 when the operand is not memory
- readyIn  in  1  execute accepts the operand set
- readCountOut  out  32  completed reads since reset; wraps 2^32-1 -> 0

## Operation
- FSM states: IDLE, RD_SRC1, RD_SRC2, RD_DEST, DONE.
- Accept condition: acValidIn && !flushIn && (state==IDLE || (state==DONE && readyIn)).
- On accept:
  - latch the three flags and three addresses;
  - clear all three data registers to 0;
  - next state is the first of RD_SRC1/RD_SRC2/RD_DEST whose flag is set, else DONE.
- IDLE or DONE+readyIn without acValidIn -> IDLE.
- RD_x:
  - memReqOut=1 and memAddrOut=latched address x, both held stable until memAckIn.
  - On memAckIn: capture memDataIn into register x, increment readCountOut, advance to the next flagged read in order, else DONE.
- DONE: opValidOut=1; data outputs stable until the readyIn handshake.
- memReqOut=0 and memAddrOut=0 outside RD_* states. memAckIn outside RD_* is ignored and does not increment the count.
- stallOut = !(state==IDLE || (state==DONE && readyIn)). This is combinational from state and readyIn.
- flushIn has highest priority:
  - next state IDLE; opValidOut falls the next cycle;
  - same-cycle acValidIn is discarded;
  - an in-flight read is abandoned, memReqOut drops next cycle, and its late ack is ignored;
  - a memAckIn in the flush cycle itself is not captured and not counted.
- The memory port never withdraws a request except on flush or reset.

## Timing
- Reset (async, any state, including mid-read):
  - state IDLE; all data registers 0; latched addresses and flags 0; readCountOut 0;
  - opValidOut, memReqOut, memAddrOut and stallOut all 0.
- Accept on edge t with no memory operands: opValidOut=1 after t+1.
- With n flagged reads, each acked in the first request cycle: memReqOut in cycles t+1..t+n, opValidOut after edge t+n+1. Each extra wait cycle adds one cycle of latency.
- Ack in the same cycle as the request is legal (minimum one cycle per read).
- Back-to-back: DONE with readyIn and acValidIn in the same cycle accepts the new instruction with no bubble.
- All outputs except stallOut are registered or decoded from registered state only.

## Test plan
- Reset mid-RD_SRC2 with memReqOut=1 -> memReqOut/opValidOut/stallOut=0 and readCountOut=0 immediately; next accept behaves normally.
- acValidIn with no memory flags, readyIn=1 -> opValidOut=1 one cycle later, all data 0, no memReqOut, readCountOut unchanged.
- All three flags set, addresses 0x1000/0x2000/0x3000, same-cycle acks with data 0xA/0xB/0xC:
  - memAddrOut sequence is 0x1000, 0x2000, 0x3000;
  - outputs are 0xA/0xB/0xC and opValidOut rises after 4 edges;
  - readCountOut=3.
- Only dest flagged, ack delayed 3 cycles -> memAddrOut held constant 4 cycles; stallOut=1 throughout; src1/src2 data 0; destDataOut = ack data.
- DONE with readyIn=0 for 5 cycles -> outputs stable and stallOut=1; then readyIn=1 with acValidIn=1 -> new instruction accepted with no idle cycle.
- flushIn during RD_SRC1, ack arrives one cycle later -> ack ignored, readCountOut unchanged, state IDLE, opValidOut never asserted.
